axi_mem_responder: RTL

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

---
 rtl/axi_mem_responder.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_mem_responder.sv
// AXI4 INCR-only burst responder over a 2^MEM_DEPTH_LOG2-word memory.
// Define AXI_MEM_BACKPRESSURE_EN to throttle wready/rvalid with an LFSR.
module axi_mem_responder #(
  parameter int ADDR_WIDTH     = 48,
  parameter int DATA_WIDTH     = 64,
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [1:0]              s_axi_bresp,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast
);
  localparam int IW = MEM_DEPTH_LOG2;
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_e;

  wstate_e w_q, w_d;
  rstate_e r_q, r_d;

  logic [IW-1:0]         widx_q, ridx_q, rd_idx;
  logic [7:0]            wlen_q, wcnt_q, rlen_q, rcnt_q;
  logic                  werr_q, wlerr_q, rerr_q;
  logic [DATA_WIDTH-1:0] mem_q [1<<IW];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic aw_hs, w_hs, ar_hs, r_hs;
  logic w_final, r_final, mem_we, rd_en;
  logic w_gate, r_gate;
  logic unused_addr_lsbs;

  // Out of range when the last word index overflows or high bits are set.
  function automatic logic burst_bad(input logic [ADDR_WIDTH-1:0] a,
                                     input logic [7:0] len);
    logic [IW:0] last;
    last = {1'b0, a[IW+2:3]} + (IW+1)'(len);
    return (|a[ADDR_WIDTH-1:IW+3]) | last[IW];
  endfunction

  assign unused_addr_lsbs = ^{s_axi_awaddr[2:0], s_axi_araddr[2:0]};

  assign aw_hs   = s_axi_awvalid & s_axi_awready;
  assign w_hs    = s_axi_wvalid & s_axi_wready;
  assign ar_hs   = s_axi_arvalid & s_axi_arready;
  assign r_hs    = s_axi_rvalid & s_axi_rready;
  assign w_final = (wcnt_q == wlen_q);
  assign r_final = (rcnt_q == rlen_q);
  assign mem_we  = w_hs & ~werr_q & ~rst;
  assign rd_en   = (r_q == R_FETCH) | (r_hs & ~r_final);
  assign rd_idx  = (r_q == R_FETCH) ? ridx_q : ridx_q + IW'(1);
  assign s_axi_rdata = rdata_q;

`ifdef AXI_MEM_BACKPRESSURE_EN
  logic [15:0] lfsr_q;
  logic        rhold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q  <= 16'hACE1;
      rhold_q <= 1'b0;
    end else begin
      lfsr_q  <= {lfsr_q[14:0],
                  lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      rhold_q <= s_axi_rvalid & ~s_axi_rready;
    end
  end

  assign w_gate = lfsr_q[0];
  assign r_gate = lfsr_q[0] | rhold_q;
`else
  assign w_gate = 1'b1;
  assign r_gate = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q <= W_IDLE;
      r_q <= R_IDLE;
    end else begin
      w_q <= w_d;
      r_q <= r_d;
    end
  end

  always_comb begin
    w_d = w_q;
    unique case (w_q)
      W_IDLE:  if (aw_hs) w_d = W_DATA;
      W_DATA:  if (w_hs && w_final) w_d = W_RESP;
      W_RESP:  if (s_axi_bready) w_d = W_IDLE;
      default: w_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_d = r_q;
    unique case (r_q)
      R_IDLE:  if (ar_hs) r_d = R_FETCH;
      R_FETCH: r_d = R_DATA;
      R_DATA:  if (r_hs && r_final) r_d = R_IDLE;
      default: r_d = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bresp   = 2'b00;
    unique case (w_q)
      W_IDLE: s_axi_awready = 1'b1;
      W_DATA: s_axi_wready  = w_gate;
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        s_axi_bresp  = (werr_q | wlerr_q) ? 2'b10 : 2'b00;
      end
      default: ;
    endcase
  end

  always_comb begin
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rlast   = 1'b0;
    s_axi_rresp   = 2'b00;
    unique case (r_q)
      R_IDLE:  s_axi_arready = 1'b1;
      R_FETCH: ;
      R_DATA: begin
        s_axi_rvalid = r_gate;
        s_axi_rlast  = r_final;
        s_axi_rresp  = rerr_q ? 2'b10 : 2'b00;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      widx_q  <= '0;
      wlen_q  <= '0;
      wcnt_q  <= '0;
      werr_q  <= 1'b0;
      wlerr_q <= 1'b0;
      ridx_q  <= '0;
      rlen_q  <= '0;
      rcnt_q  <= '0;
      rerr_q  <= 1'b0;
    end else begin
      if (aw_hs) begin
        widx_q  <= s_axi_awaddr[IW+2:3];
        wlen_q  <= s_axi_awlen;
        wcnt_q  <= '0;
        werr_q  <= burst_bad(s_axi_awaddr, s_axi_awlen);
        wlerr_q <= 1'b0;
      end else if (w_hs) begin
        widx_q <= widx_q + IW'(1);
        wcnt_q <= wcnt_q + 8'd1;
        if (s_axi_wlast != w_final) wlerr_q <= 1'b1;
      end
      if (ar_hs) begin
        ridx_q <= s_axi_araddr[IW+2:3];
        rlen_q <= s_axi_arlen;
        rcnt_q <= '0;
        rerr_q <= burst_bad(s_axi_araddr, s_axi_arlen);
      end else if (r_hs) begin
        ridx_q <= ridx_q + IW'(1);
        rcnt_q <= rcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < SW; b++) begin
        if (s_axi_wstrb[b]) mem_q[widx_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // The output register doubles as the prefetch stage for the next beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= rerr_q ? '0 : mem_q[rd_idx];
    end
  end

endmodule
